// File: rtl/dual_rail_pkg.sv
// dual_rail_pkg: shared rail indices, encodings and capture states for the dual-rail link blocks
package dual_rail_pkg;
    localparam int RAIL_NUM = 2;
    localparam int RAIL_T = 1;
    localparam int RAIL_F = 0;
    localparam string ENC_TP = "TP";
    localparam string ENC_FP = "FP";
    typedef enum logic [1:0] {WAIT_TOKEN, HOLD, WAIT_SPACER} cap_state_t;
endpackage

// File: rtl/dual_rail_value_capture_if.sv
// dual_rail_value_capture_if: dual-rail link plus decoded valid/ready output bundle
interface dual_rail_value_capture_if #(parameter int WIDTH = 1);
    import dual_rail_pkg::*;
    logic [WIDTH-1:0][RAIL_NUM-1:0] in;
    logic ack;
    logic [WIDTH-1:0] out_data;
    logic out_valid;
    logic out_ready;
    logic err;
    modport master(input in, out_ready, output ack, out_data, out_valid, err);
    modport slave(output in, out_ready, input ack, out_data, out_valid, err);
endinterface

// File: rtl/dual_rail_sync.sv
// dual_rail_sync: N-stage flop synchronizer for every rail of a dual-rail vector
module dual_rail_sync
    import dual_rail_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0] d,
    output logic [WIDTH-1:0][RAIL_NUM-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0][RAIL_NUM-1:0] ff;
    always_ff @(posedge clk or negedge rst)
        if (!rst) ff <= '0;
        else ff <= {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/dual_rail_value_capture.sv
// dual_rail_value_capture: synchronizes a TP/FP dual-rail link and presents tokens on valid/ready
module dual_rail_value_capture
    import dual_rail_pkg::*;
#(
    parameter string ENC = "TP",
    parameter int WIDTH = 1,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst,
    dual_rail_value_capture_if.master bus
);
    if (ENC != ENC_TP && ENC != ENC_FP) begin : g_bad_enc
        $fatal(1, "dual_rail_value_capture: ENC must be TP or FP");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "dual_rail_value_capture: SYNC_STAGES must be at least 2");
    end
    localparam bit IS_TP = (ENC == ENC_TP);
    logic [WIDTH-1:0][RAIL_NUM-1:0] s, snap, snap_nx, chg;
    logic [WIDTH-1:0] done, val, bad, data_nx;
    logic valid_nx, ack_nx, err_nx;
    cap_state_t state, state_nx;
    dual_rail_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .d(bus.in),
        .q(s)
    );
    // TP looks at rail transitions since the last consumed token, FP at rail levels
    assign chg = IS_TP ? s ^ snap : s;
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            done[i] = chg[i][RAIL_T] | chg[i][RAIL_F];
            val[i] = chg[i][RAIL_T];
            bad[i] = chg[i][RAIL_T] & chg[i][RAIL_F];
        end
    end
    always_comb begin
        state_nx = state;
        snap_nx = snap;
        data_nx = bus.out_data;
        valid_nx = bus.out_valid;
        ack_nx = bus.ack;
        err_nx = bus.err;
        case (state)
            WAIT_TOKEN: if (&done) begin
                data_nx = val;
                valid_nx = 1'b1;
                err_nx = bus.err | (|bad);
                state_nx = HOLD;
            end
            HOLD: if (bus.out_ready) begin
                valid_nx = 1'b0;
                ack_nx = IS_TP ? ~bus.ack : 1'b1;
                snap_nx = IS_TP ? s : snap;
                state_nx = IS_TP ? WAIT_TOKEN : WAIT_SPACER;
            end
            WAIT_SPACER: if (s == '0) begin
                ack_nx = 1'b0;
                state_nx = WAIT_TOKEN;
            end
            default: state_nx = WAIT_TOKEN;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= WAIT_TOKEN;
            snap <= '0;
            bus.out_data <= '0;
            bus.out_valid <= 1'b0;
            bus.ack <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            state <= state_nx;
            snap <= snap_nx;
            bus.out_data <= data_nx;
            bus.out_valid <= valid_nx;
            bus.ack <= ack_nx;
            bus.err <= err_nx;
        end
endmodule

// File: tb/tb_dual_rail_value_capture.sv
// tb_dual_rail_value_capture: directed vector bench for TP/FP capture, backpressure, skew, errors and reset
module tb_dual_rail_value_capture;
    logic clk = 1'b0;
    logic rst;
    int n_vec = 0;
    int n_bad = 0;
    dual_rail_value_capture_if #(.WIDTH(4)) bt();
    dual_rail_value_capture_if #(.WIDTH(4)) bf();
    dual_rail_value_capture_if #(.WIDTH(8)) b8();
    dual_rail_value_capture #(.ENC("TP"), .WIDTH(4), .SYNC_STAGES(2)) u_tp (.clk(clk), .rst(rst), .bus(bt));
    dual_rail_value_capture #(.ENC("FP"), .WIDTH(4), .SYNC_STAGES(2)) u_fp (.clk(clk), .rst(rst), .bus(bf));
    dual_rail_value_capture #(.ENC("TP"), .WIDTH(8), .SYNC_STAGES(2)) u_sk (.clk(clk), .rst(rst), .bus(b8));
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0][1:0] rails;
        logic [3:0] data;
        logic err;
    } tp_vec_t;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    initial begin
        tp_vec_t tbl[5];
        logic ack_exp;
        logic [7:0][1:0] r;
        int lat;
        tbl[0] = '{8'h66, 4'b0101, 1'b0};
        tbl[1] = '{8'hCC, 4'b1111, 1'b0};
        tbl[2] = '{8'h99, 4'b0000, 1'b0};
        tbl[3] = '{8'h0F, 4'b1001, 1'b0};
        tbl[4] = '{8'hA8, 4'b1101, 1'b1};
        rst = 1'b0;
        bt.in = '0; bf.in = '0; b8.in = '0;
        bt.out_ready = 1'b1; bf.out_ready = 1'b0; b8.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_tp_valid", bt.out_valid, 0); check("rst_tp_data", bt.out_data, 0);
        check("rst_tp_ack", bt.ack, 0); check("rst_tp_err", bt.err, 0);
        check("rst_fp_valid", bf.out_valid, 0); check("rst_fp_data", bf.out_data, 0);
        check("rst_fp_ack", bf.ack, 0); check("rst_fp_err", bf.err, 0);
        check("rst_sk_valid", b8.out_valid, 0); check("rst_sk_data", b8.out_data, 0);
        check("rst_sk_ack", b8.ack, 0); check("rst_sk_err", b8.err, 0);
        // TP table, consumer always ready: one-cycle valid then an ack toggle per token
        ack_exp = 1'b0;
        for (int v = 0; v < 5; v++) begin
            bt.in = tbl[v].rails;
            lat = 0;
            do begin @(negedge clk); lat++; end while (!bt.out_valid && lat < 20);
            check("tp_latency", lat, 3);
            check("tp_data", bt.out_data, tbl[v].data);
            check("tp_err", bt.err, tbl[v].err);
            check("tp_ack_hold", bt.ack, ack_exp);
            ack_exp = ~ack_exp;
            @(negedge clk);
            check("tp_valid_drop", bt.out_valid, 0);
            check("tp_ack", bt.ack, ack_exp);
        end
        // FP token 0xA under 10 cycles of backpressure
        bf.in = 8'h99;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bf.out_valid && lat < 20);
        check("fp_latency", lat, 3);
        check("fp_data", bf.out_data, 4'hA);
        check("fp_err", bf.err, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", bf.out_valid, 1);
            check("bp_data", bf.out_data, 4'hA);
            check("bp_ack", bf.ack, 0);
        end
        bf.out_ready = 1'b1;
        @(negedge clk);
        check("fp_valid_drop", bf.out_valid, 0);
        check("fp_ack_rise", bf.ack, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("fp_ack_wait_spacer", bf.ack, 1);
        end
        bf.in = '0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (bf.ack && lat < 20);
        check("fp_spacer_latency", lat, 3);
        // FP codeword with both rails high on bit 0, then a clean token
        bf.in = 8'h9B;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bf.out_valid && lat < 20);
        check("fp_err_data", bf.out_data, 4'hB);
        check("fp_err_set", bf.err, 1);
        @(negedge clk);
        check("fp_err_ack", bf.ack, 1);
        bf.in = '0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (bf.ack && lat < 20);
        check("fp_err_spacer", lat, 3);
        bf.in = 8'h66;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bf.out_valid && lat < 20);
        check("fp_good_data", bf.out_data, 4'h5);
        check("fp_err_sticky", bf.err, 1);
        @(negedge clk);
        bf.in = '0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (bf.ack && lat < 20);
        check("fp_good_spacer", lat, 3);
        check("fp_err_sticky2", bf.err, 1);
        // Skewed arrival on the 8-bit TP link, one bit every 3 cycles
        r = '0;
        for (int b = 0; b < 8; b++) begin
            r[b] = (b % 2) ? 2'b01 : 2'b10;
            b8.in = r;
            if (b < 7)
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("skew_no_valid", b8.out_valid, 0);
                end
        end
        lat = 0;
        do begin @(negedge clk); lat++; end while (!b8.out_valid && lat < 20);
        check("skew_latency", lat, 3);
        check("skew_data", b8.out_data, 8'h55);
        @(negedge clk);
        check("skew_ack", b8.ack, 1);
        // Asynchronous reset while the FP side sits in HOLD
        bf.out_ready = 1'b0;
        bf.in = 8'h66;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bf.out_valid && lat < 20);
        check("rst_hold_data", bf.out_data, 4'h5);
        #2 rst = 1'b0;
        bt.in = '0; bf.in = '0; b8.in = '0;
        #1;
        check("arst_fp_valid", bf.out_valid, 0);
        check("arst_fp_data", bf.out_data, 0);
        check("arst_fp_ack", bf.ack, 0);
        check("arst_fp_err", bf.err, 0);
        check("arst_tp_ack", bt.ack, 0);
        check("arst_tp_err", bt.err, 0);
        check("arst_sk_ack", b8.ack, 0);
        @(negedge clk);
        rst = 1'b1;
        bf.in = 8'h99;
        bf.out_ready = 1'b1;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bf.out_valid && lat < 20);
        check("post_rst_latency", lat, 3);
        check("post_rst_data", bf.out_data, 4'hA);
        check("post_rst_err", bf.err, 0);
        @(negedge clk);
        check("post_rst_ack", bf.ack, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dual_rail_value_capture.md
# dual_rail_value_capture

Clocked receiver that terminates a dual-rail link, built from value-inject and similar stages, into the synchronous domain. It synchronizes every rail, detects token completion per bit in two-phase (TP) or four-phase (FP) encoding, and presents the decoded word on a valid/ready interface. It returns an acknowledge to the link sender. It sits directly downstream of `dual_rail_value_inject` and consumes the tokens that block produces.

## Interface
- `ENC`, default "TP": link encoding, "TP" (transition signalling) or "FP" (return-to-zero).
- `WIDTH`, default 1: data bits per token.
- `SYNC_STAGES`, default 2: flops per rail in the synchronizer, minimum 2.
- `RAIL_NUM` (localparam), 2.
- `clk` in, 1: single clock.
- `rst` in, 1: asynchronous, active-low reset.
- `in` in, [WIDTH-1:0][RAIL_NUM-1:0]: dual-rail link; rail 1 means value 1, rail 0 means value 0.
- `ack` out, 1: link acknowledge. TP toggles once per token. FP is a level (1 = token taken, 0 = spacer seen).
- `out_data` out, WIDTH: decoded word.
- `out_valid` out, 1: `out_data` holds a token.
- `out_ready` in, 1: consumer accepts the token when `out_valid && out_ready`.
- `err` out, 1: sticky illegal-codeword flag.

## Operation
- All rails pass through `SYNC_STAGES` flops. Only the synchronized rails `s` are used afterwards.
- TP:
  - A snapshot register `snap` holds the rails from the last consumed token.
  - Bit i is complete when `s[i] != snap[i]`.
  - Value is 1 if rail 1 changed, else 0.
  - If both rails of a bit changed, the bit is complete, its value is 1, and `err` is set.
- FP:
  - Bit i is complete when exactly one rail is high. Value equals `s[i][1]`.
  - Both rails high counts as complete, value 1, and sets `err`.
- Token complete means every bit is complete. A partially arrived token waits indefinitely.
- FSM states: WAIT_TOKEN, HOLD, WAIT_SPACER (WAIT_SPACER is FP only).
  - WAIT_TOKEN: on token complete, register `out_data` with the decoded value, set `out_valid`=1, go to HOLD.
  - HOLD: `out_data` is held stable and `out_valid` stays 1 until `out_ready`. On handshake, `out_valid`=0, then:
    - TP: toggle `ack`, set `snap` <= `s`, go to WAIT_TOKEN.
    - FP: set `ack`=1, go to WAIT_SPACER.
  - WAIT_SPACER: when all rails of `s` are 0, set `ack`=0 and go to WAIT_TOKEN.
- Capacity is one token. The upstream cannot send the next token until `ack` moves, so link backpressure follows from `out_ready`.
- `err` clears only on reset. Error tokens are still delivered.
- An unknown `ENC` value elaborates to a fatal error.

## Timing
- Reset values:
  - Outputs: `out_valid`=0, `out_data`=0, `ack`=0, `err`=0.
  - Internal: `snap`=0, sync flops 0, state WAIT_TOKEN.
- Reset mid-operation returns to these values immediately. The link sender must be reset together with this block, because rails are assumed all-zero and `ack`=0 after reset.
- Latency from input to output: `out_valid` rises `SYNC_STAGES`+1 cycles after the last rail edge of a token reaches the first sync flop.
- `ack` rises, falls or toggles on the clock edge after the `out_valid && out_ready` handshake.
- FP spacer detect: `ack` falls `SYNC_STAGES`+1 cycles after the last rail falls.
- `out_ready` high in the same cycle `out_valid` rises completes the handshake in that cycle. Minimum HOLD residency is 1 cycle.
- Peak throughput:
  - TP: one token per 2·`SYNC_STAGES`+3 cycles, limited by the sender's round trip.
  - FP: roughly twice the TP figure.
- `out_ready` is ignored when `out_valid`=0.
- Rails changing during HOLD are ignored. TP rails changing during HOLD are a protocol violation and are not flagged.

## Structure
- Shared package `dual_rail_pkg` holds:
  - `RAIL_NUM`.
  - Rail index constants `RAIL_T`=1 and `RAIL_F`=0.
  - Capture state enum `cap_state_t`.
  - Encoding string constants "TP" and "FP", shared with `dual_rail_value_inject`.
- Sub-module `dual_rail_sync`: a parameterized N-stage flop synchronizer on a [WIDTH-1:0][RAIL_NUM-1:0] vector with async active-low reset. It is instantiated once.
- Completion detect, decode and the FSM live in this module.

## Test plan
- TP, WIDTH=4, `out_ready`=1:
  - Stimulus: toggle rail 1 of bits 0 and 2 and rail 0 of bits 1 and 3.
  - Required: `out_data`=4'b0101 with `out_valid` for 1 cycle, `ack` 0→1, `err`=0.
  - Follow-up: the next token toggling all rail 1s gives 4'b1111 and `ack` 1→0.
- FP, WIDTH=4:
  - Stimulus: drive 0xA as one-hot rails.
  - Required: `out_data`=4'hA and `ack`=1 after handshake. `ack` stays 1 until all rails are 0, then goes to 0 `SYNC_STAGES`+1 cycles later.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - Required: `out_data`/`out_valid` stable, `ack` unchanged, and a second input token is not accepted until after the handshake.
- Skewed arrival, WIDTH=8:
  - Stimulus: bits arrive one per 3 cycles.
  - Required: `out_valid` stays 0 until bit 7 arrives, then rises `SYNC_STAGES`+1 cycles after it.
- Errors:
  - Stimulus: FP bit with both rails high.
  - Required: `err`=1, that bit decodes to 1, `err` stays 1 over later good tokens and clears only on reset.
- Reset:
  - Stimulus: assert `rst`=0 while in HOLD (FP).
  - Required: `out_valid`, `ack`, `err` are all 0 asynchronously. After release with rails 0, a new token is captured normally.
